// File: rtl/rf_pkg.sv
// Shared register-file package: geometry constants and the write-port bundle.
// Imported by reg_file and by the write-back arbiter.
package rf_pkg;

  localparam int unsigned DATA_WIDTH  = 64;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned INDEX_WIDTH = $clog2(NUM_REGS);

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]  data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// ptr moves past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] gidx;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PtrW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (32'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus a
// per-register pending scoreboard used by issue to stall on RAW hazards.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DataWidth  = DATA_WIDTH,
  parameter int unsigned NumRegs    = NUM_REGS,
  parameter int unsigned IndexWidth = $clog2(NumRegs),
  parameter int unsigned NumReq     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NumReq-1:0]            req_valid,
  output logic [NumReq-1:0]            req_ready,
  input  logic [NumReq*IndexWidth-1:0] req_addr,
  input  logic [NumReq*DataWidth-1:0]  req_data,
  input  logic                         reserveEn,
  input  logic [IndexWidth-1:0]        reserveAddr,
  output logic [NumRegs-1:0]           pending,
  output logic                         writeEn,
  output logic [IndexWidth-1:0]        writeAddr,
  output logic [DataWidth-1:0]         writeData
);

  logic [NumReq-1:0]     req_gated;
  logic [NumReq-1:0]     grant;
  logic                  xfer;
  logic [IndexWidth-1:0] sel_addr;
  logic [DataWidth-1:0]  sel_data;
  logic [NumRegs-1:0]    pending_d;

  // Nothing is granted during reset, so no write can be registered then.
  assign req_gated = rst ? '0 : req_valid;

  rr_arbiter #(
    .N(NumReq)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_gated),
    .advance(xfer),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*IndexWidth +: IndexWidth];
        sel_data = req_data[i*DataWidth +: DataWidth];
      end
    end
  end

  // x0 writes are accepted but never reach the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else if (xfer) begin
      writeEn   <= (sel_addr != '0);
      writeAddr <= sel_addr;
      writeData <= sel_data;
    end else begin
      writeEn   <= 1'b0;
    end
  end

  // Reserve beats a same-cycle commit: the reservation is a newer producer.
  always_comb begin
    pending_d = pending;
    for (int unsigned a = 1; a < NumRegs; a++) begin
      if (reserveEn && (32'(reserveAddr) == a)) begin
        pending_d[a] = 1'b1;
      end else if (writeEn && (32'(writeAddr) == a)) begin
        pending_d[a] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of arbitration, write port, scoreboard and reg file.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned NR = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned NQ = 2;

  logic             clk;
  logic             rst;
  logic [NQ-1:0]    req_valid;
  logic [NQ-1:0]    req_ready;
  logic [NQ*IW-1:0] req_addr;
  logic [NQ*DW-1:0] req_data;
  logic             reserveEn;
  logic [IW-1:0]    reserveAddr;
  logic [NR-1:0]    pending;
  logic             writeEn;
  logic [IW-1:0]    writeAddr;
  logic [DW-1:0]    writeData;

  rf_wb_arbiter #(
    .DataWidth (DW),
    .NumRegs   (NR),
    .IndexWidth(IW),
    .NumReq    (NQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .reserveEn  (reserveEn),
    .reserveAddr(reserveAddr),
    .pending    (pending),
    .writeEn    (writeEn),
    .writeAddr  (writeAddr),
    .writeData  (writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in reg_file fed by the DUT write port, and the reference model state.
  logic [DW-1:0] rf_mem [NR];
  logic [DW-1:0] m_rf   [NR];
  int            m_ptr;
  logic          m_we;
  logic [IW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [NR-1:0] m_pend;
  int            last_grant;

  task automatic set_req(input int i, input logic [IW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*IW +: IW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Called at a negedge with inputs driven; returns at the next negedge.
  task automatic tick();
    int            g;
    logic [NQ-1:0] exp_ready;
    logic          dut_we;
    logic [IW-1:0] dut_wa;
    logic [DW-1:0] dut_wd;
    logic [IW-1:0] a;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < int'(NQ); k++) begin
        int i;
        i = (m_ptr + k) % int'(NQ);
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    dut_we = writeEn;
    dut_wa = writeAddr;
    dut_wd = writeData;
    last_grant = g;
    @(posedge clk);
    if (!rst && dut_we) rf_mem[dut_wa] = dut_wd;
    if (!rst && m_we) m_rf[m_wa] = m_wd;
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_pend = '0;
    end else begin
      if (m_we) m_pend[m_wa] = 1'b0;
      if (reserveEn && reserveAddr != 0) m_pend[reserveAddr] = 1'b1;
      if (g >= 0) begin
        a     = req_addr[g*IW +: IW];
        m_we  = (a != 0);
        m_wa  = a;
        m_wd  = req_data[g*DW +: DW];
        m_ptr = (g + 1) % int'(NQ);
      end else begin
        m_we = 1'b0;
      end
    end
    @(negedge clk);
    check("writeEn", 64'(writeEn), 64'(m_we));
    check("writeAddr", 64'(writeAddr), 64'(m_wa));
    check("writeData", writeData, m_wd);
    check("pending", 64'(pending), 64'(m_pend));
  endtask

  localparam logic [DW-1:0] Single = 64'h0123_4567_89AB_CDEF;

  initial begin
    logic [NQ-1:0] prev_valid;
    for (int i = 0; i < int'(NR); i++) begin
      rf_mem[i] = '0;
      m_rf[i]   = '0;
    end
    m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_pend = '0; last_grant = -1;
    req_addr = '0; req_data = '0; reserveEn = 1'b0; reserveAddr = '0;

    // Reset held two cycles with both requesters valid.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    set_req(0, 5'd3, 64'h1);
    set_req(1, 5'd4, 64'h2);
    #1 check("rst_ready", 64'(req_ready), 64'h0);
    tick();
    tick();
    check("rst_writeEn", 64'(writeEn), 64'h0);
    check("rst_pending", 64'(pending), 64'h0);

    // Fairness from release: 0,1,0,1,0,1 with write addresses 3,4,3,4,3,4.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 check("fair_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check("fair_addr", 64'(writeAddr), (i % 2 == 0) ? 64'd3 : 64'd4);
    end

    // Single write, then read back through the reg file one cycle later.
    req_valid = 2'b01;
    set_req(0, 5'd5, Single);
    #1 check("single_ready", 64'(req_ready), 64'h1);
    tick();
    check("single_we", 64'(writeEn), 64'h1);
    check("single_addr", 64'(writeAddr), 64'd5);
    check("single_data", writeData, Single);
    req_valid = 2'b00;
    tick();
    check("single_read", rf_mem[5], Single);

    // x0: accepted, dropped, never reservable.
    req_valid = 2'b10;
    set_req(1, 5'd0, '1);
    #1 check("x0_ready", 64'(req_ready), 64'h2);
    tick();
    check("x0_we", 64'(writeEn), 64'h0);
    req_valid   = 2'b00;
    reserveEn   = 1'b1;
    reserveAddr = 5'd0;
    tick();
    check("x0_pending", 64'(pending[0]), 64'h0);
    check("x0_read", rf_mem[0], 64'h0);

    // Scoreboard set/clear, then set winning over a simultaneous clear.
    reserveAddr = 5'd7;
    tick();
    check("sb_set", 64'(pending[7]), 64'h1);
    reserveEn = 1'b0;
    req_valid = 2'b01;
    set_req(0, 5'd7, 64'h77);
    tick();
    check("sb_hold", 64'(pending[7]), 64'h1);
    req_valid = 2'b00;
    tick();
    check("sb_clear", 64'(pending[7]), 64'h0);
    reserveEn = 1'b1;
    tick();
    reserveEn = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    reserveEn = 1'b1;
    tick();
    check("sb_set_wins", 64'(pending[7]), 64'h1);
    reserveEn = 1'b0;

    // Reset right after a transfer: write discarded, pointer back to 0.
    req_valid   = 2'b01;
    set_req(0, 5'd9, 64'hDEAD);
    reserveEn   = 1'b1;
    reserveAddr = 5'd9;
    tick();
    rst       = 1'b1;
    req_valid = 2'b00;
    reserveEn = 1'b0;
    tick();
    check("mid_rst_we", 64'(writeEn), 64'h0);
    check("mid_rst_pending", 64'(pending), 64'h0);
    rst       = 1'b0;
    req_valid = 2'b11;
    set_req(0, 5'd3, 64'h1);
    set_req(1, 5'd4, 64'h2);
    #1 check("mid_rst_ptr", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();
    check("mid_rst_rf", rf_mem[9], 64'h0);

    // Random traffic; held requests keep addr/data until served or dropped.
    prev_valid = 2'b00;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NQ); i++) begin
        if (prev_valid[i] && last_grant != i) begin
          req_valid[i] = ($urandom_range(3) != 0);
        end else begin
          req_valid[i] = $urandom_range(1) == 1;
          set_req(i, IW'($urandom_range(7)), {$urandom, $urandom});
        end
      end
      reserveEn   = $urandom_range(2) == 0;
      reserveAddr = IW'($urandom_range(7));
      rst         = ($urandom_range(99) == 0);
      prev_valid  = rst ? 2'b00 : req_valid;
      tick();
    end
    rst = 1'b0;
    req_valid = 2'b00;
    reserveEn = 1'b0;
    tick();
    tick();
    for (int a = 0; a < int'(NR); a++) check("rf_final", rf_mem[a], m_rf[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-register scoreboard for the 64-bit, 32-entry register file (`reg_file`: one write port, two combinational read ports). It shares the register file's single write port among `NumReq` write-back sources using round-robin, valid/ready arbitration. It drives the write port from registered outputs and tracks which destination registers have an outstanding producer, so issue logic can stall on read-after-write hazards.

## Interface
- `DataWidth`, 64, width of write data
- `NumRegs`, 32, number of architectural registers
- `IndexWidth`, `$clog2(NumRegs)`, register address width
- `NumReq`, 2, number of write-back requesters (≥2)

- `clk`  in  1  clock; all state on the rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `req_valid`  in  NumReq  requester i has a write pending
- `req_ready`  out  NumReq  requester i is granted this cycle
- `req_addr`  in  NumReq*IndexWidth  destination register address; requester i in slice i
- `req_data`  in  NumReq*DataWidth  write data; requester i in slice i
- `reserveEn`  in  1  issue marks a destination register as pending
- `reserveAddr`  in  IndexWidth  register to mark
- `pending`  out  NumRegs  per-register outstanding-write flags
- `writeEn`  out  1  to `reg_file.writeEn`
- `writeAddr`  out  IndexWidth  to `reg_file.writeAddr`
- `writeData`  out  DataWidth  to `reg_file.writeData`

## Operation
- Round-robin pointer `ptr` (range 0..NumReq-1).
  - Grant goes to the first requester with `req_valid[i]=1`, searching from `ptr` upward with wrap-around.
  - `req_ready` is one-hot for the granted requester and all-zero when no requester is valid.
- Transfer: `req_valid[i] & req_ready[i]`. At most one transfer per cycle.
  - On a transfer, `ptr` ← granted index + 1 (mod NumReq). With no transfer, `ptr` holds.
- Output registers, on each edge:
  - `writeEn` ← transfer & (addr ≠ 0).
  - `writeAddr`/`writeData` ← the granted requester's addr/data.
  - `writeAddr`/`writeData` hold their value when there is no transfer.
- Address 0 is hardwired zero:
  - A request to address 0 is accepted (ready given) and silently dropped.
  - `reserveEn` with address 0 is ignored.
  - `pending[0]` is always 0.
- Scoreboard, on each edge:
  - `pending[a]` is set if `reserveEn & reserveAddr==a & a≠0`.
  - Otherwise `pending[a]` is cleared if `writeEn & writeAddr==a`, i.e. the edge at which `reg_file` commits the write.
  - Simultaneous set and clear of the same address: set wins (a newer producer exists).
  - A write to a non-pending register is legal and leaves the flag at 0.
- Requesters must hold `req_addr`/`req_data` stable while valid and not ready. Dropping valid before ready is allowed; that request is simply never served.
- Reset: `ptr`=0, `writeEn`=0, `writeAddr`=0, `writeData`=0, `pending`=0.
  - A write registered in the cycle `rst` is sampled high is discarded.
  - `req_ready` is forced to 0 while `rst`=1.

## Timing
- `req_ready` is combinational from `req_valid`, `ptr` and `rst`. There is no combinational path from `req_addr`/`req_data` to any output.
- Latency: a transfer at edge k gives `writeEn`=1 during cycle k..k+1. `reg_file` commits at edge k+1, and `pending` clears at edge k+1.
- The new value is readable on `reg_file` read ports from the cycle after edge k+1. Readers must not read while `pending` is 1.
- Reserve at edge k: `pending` is visible from the cycle after edge k.
- Throughput is one write per cycle. With all NumReq requesters valid continuously, each is served exactly once every NumReq cycles.

## Structure
- Shared package `rf_pkg`:
  - constants `DATA_WIDTH`=64, `NUM_REGS`=32, `INDEX_WIDTH`.
  - struct `rf_wr_t` {addr, data}.
  - This block and `reg_file` import the same package.
- Sub-module `rr_arbiter` (parameter `N`; inputs `req`, `advance`; output one-hot `grant`; internal `ptr`) holds the pointer and priority search.
- The top level holds the output registers, the x0 filter and the scoreboard.

## Test plan
- Reset: hold `rst` 2 cycles with `req_valid`=2'b11 → `req_ready`=0, `writeEn`=0, `pending`=0. The first grant after release goes to requester 0.
- Single write: req0 valid, addr 5, data 64'h0123_4567_89AB_CDEF → `req_ready[0]`=1. Next cycle `writeEn`=1, `writeAddr`=5, `writeData` matches. One cycle later, `reg_file` `readData1` at `readAddr1`=5 returns the value.
- Fairness: both valid for 6 cycles (req0 → addr 3, data 'h1; req1 → addr 4, data 'h2) → grants go 0,1,0,1,0,1 and `writeAddr` sequence is 3,4,3,4,3,4.
- x0: req1 valid, addr 0, data all-ones → ready=1, `writeEn` stays 0. `reserveEn` at addr 0 → `pending[0]` stays 0. Register 0 reads 0.
- Scoreboard: reserve addr 7 → `pending[7]`=1 next cycle. Write to 7 transfers at edge k → `pending[7]`=0 after edge k+1. Repeat with `reserveEn`/`reserveAddr`=7 on edge k+1 → `pending[7]` stays 1.
- Reset mid-operation: req0 transfer at edge k while `rst`=1 at edge k+1 → `writeEn`=0 after edge k+1, `pending` cleared, `ptr`=0; the register file location is unchanged.
